// File: rtl/i2c_reg_bank_pkg.sv
// i2c_reg_bank_pkg: register map addresses, STATUS bit indices and reset values for i2c_reg_bank.
package i2c_reg_bank_pkg;
   localparam logic [7:0] ADDR_ID       = 8'h00;
   localparam logic [7:0] ADDR_CTRL     = 8'h01;
   localparam logic [7:0] ADDR_STATUS   = 8'h02;
   localparam logic [7:0] ADDR_LEVEL    = 8'h03;
   localparam logic [7:0] ADDR_MBOX     = 8'h04;
   localparam logic [7:0] ADDR_IRQ_MASK = 8'h05;
   localparam logic [7:0] ADDR_GP_BASE  = 8'h08;
   localparam int STATUS_TX_OVF = 0;
   localparam int STATUS_RX_UNF = 1;
   localparam logic [7:0]  CTRL_RST     = 8'h00;
   localparam logic [7:0]  STATUS_RST   = 8'h00;
   localparam logic [7:0]  IRQ_MASK_RST = 8'h00;
   localparam logic [63:0] GP_RST       = 64'h0;
endpackage

// File: rtl/i2c_reg_bank_byte_fifo.sv
// byte_fifo: DEPTH-entry byte FIFO with registered full/empty/level; a pop frees room for a same-cycle push.
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic       full,
   output logic       empty,
   output logic [3:0] level,
   output logic [7:0] head
);
   localparam int PW = $clog2(DEPTH);
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;
   logic [3:0]    level_nxt;
   always_comb begin
      do_pop    = pop & ~empty;
      do_push   = push & (~full | do_pop);
      level_nxt = level + {3'b0, do_push} - {3'b0, do_pop};
      head      = empty ? 8'h00 : mem[rd_ptr];
   end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= 4'd0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
         level  <= level_nxt;
         empty  <= level_nxt == 4'd0;
         full   <= level_nxt == 4'(DEPTH);
      end
endmodule

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: I2C slave register bank with CTRL/GP/STATUS registers and TX/RX byte mailboxes.
// Define I2C_REG_BANK_IRQ_EN to add the IRQ_MASK register at 0x05 and the irq output.
module i2c_reg_bank
   import i2c_reg_bank_pkg::*;
#(
   parameter logic [7:0] ID_VALUE   = 8'hA5,
   parameter int         FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  addr,
   input  logic        wen,
   input  logic [7:0]  wdata,
   input  logic        rdata_used,
   output logic [7:0]  rdata,
   output logic [7:0]  ctrl_o,
   output logic [63:0] gp_o,
   input  logic [7:0]  status_set_i,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready
`ifdef I2C_REG_BANK_IRQ_EN
   ,
   output logic        irq
`endif
);
   logic [7:0] status, status_set, status_clr, rd_nxt, irq_rd, rx_head;
   logic [3:0] tx_level, rx_level;
   logic       tx_full, tx_empty, rx_full, rx_empty;
   logic       mbox, gp_sel, tx_push, tx_pop, rx_pop, unused_ok;
   always_comb begin
      mbox       = addr == ADDR_MBOX;
      gp_sel     = addr[7:3] == ADDR_GP_BASE[7:3];
      tx_push    = wen & mbox;
      tx_pop     = tx_ready & ~tx_empty;
      rx_pop     = rdata_used & mbox & ~rx_empty;
      tx_valid   = ~tx_empty;
      rx_ready   = ~rx_full;
      unused_ok  = ^status_set_i[1:0];
      status_set = {status_set_i[7:2], rdata_used & mbox & rx_empty, tx_push & tx_full & ~tx_pop};
      status_clr = wen && addr == ADDR_STATUS ? wdata : 8'h00;
      rd_nxt     = addr == ADDR_ID       ? ID_VALUE :
                   addr == ADDR_CTRL     ? ctrl_o :
                   addr == ADDR_STATUS   ? status :
                   addr == ADDR_LEVEL    ? {tx_level, rx_level} :
                   addr == ADDR_MBOX     ? rx_head :
                   addr == ADDR_IRQ_MASK ? irq_rd :
                   gp_sel                ? gp_o[{addr[2:0], 3'b000} +: 8] : 8'h00;
   end
   always_ff @(posedge clk)
      if (rst) begin
         rdata  <= 8'h00;
         ctrl_o <= CTRL_RST;
         gp_o   <= GP_RST;
         status <= STATUS_RST;
      end else begin
         rdata  <= rd_nxt;
         ctrl_o <= wen && addr == ADDR_CTRL ? wdata : ctrl_o;
         if (wen && gp_sel) gp_o[{addr[2:0], 3'b000} +: 8] <= wdata;
         // set is OR-ed in after the clear so a same-cycle event survives W1C
         status <= (status & ~status_clr) | status_set;
      end
`ifdef I2C_REG_BANK_IRQ_EN
   logic [7:0] irq_mask;
   always_ff @(posedge clk)
      if (rst) begin
         irq_mask <= IRQ_MASK_RST;
         irq      <= 1'b0;
      end else begin
         irq_mask <= wen && addr == ADDR_IRQ_MASK ? wdata : irq_mask;
         irq      <= |(status & irq_mask);
      end
   assign irq_rd = irq_mask;
`else
   assign irq_rd = 8'h00;
`endif
   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata),
      .full(tx_full), .empty(tx_empty), .level(tx_level), .head(tx_data)
   );
   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
      .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop), .din(rx_data),
      .full(rx_full), .empty(rx_empty), .level(rx_level), .head(rx_head)
   );
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: table-driven register checks plus directed FIFO, STATUS and IRQ sequences.
module tb_i2c_reg_bank;
   logic        clk = 1'b0, rst = 1'b1;
   logic [7:0]  addr = 8'h00, wdata = 8'h00, status_set_i = 8'h00, rx_data = 8'h00;
   logic        wen = 1'b0, rdata_used = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
   logic [7:0]  rdata, ctrl_o, tx_data;
   logic [63:0] gp_o;
   logic        tx_valid, rx_ready;
`ifdef I2C_REG_BANK_IRQ_EN
   logic        irq;
`endif
   int n_chk = 0, n_fail = 0;
   logic [7:0] v;

   always #5 clk = ~clk;

   i2c_reg_bank dut (
      .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
      .rdata_used(rdata_used), .rdata(rdata), .ctrl_o(ctrl_o), .gp_o(gp_o),
      .status_set_i(status_set_i), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
`ifdef I2C_REG_BANK_IRQ_EN
      , .irq(irq)
`endif
   );

   typedef struct {
      logic [7:0] a;
      logic       we;
      logic [7:0] wd;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl [16];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = a; wdata = d; wen = 1'b1;
      @(negedge clk);
      wen = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      addr = a;
      @(negedge clk);
      d = rdata;
   endtask

   task automatic mbox_read(output logic [7:0] d);
      @(negedge clk);
      addr = 8'h04;
      @(negedge clk);
      d = rdata;
      rdata_used = 1'b1;
      @(negedge clk);
      rdata_used = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] d);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = d;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{8'h01, 1'b1, 8'h3C, 8'h3C};
      for (int i = 0; i < 8; i++) tbl[1+i] = '{8'h08 + 8'(i), 1'b1, 8'h11 + 8'(i), 8'h11 + 8'(i)};
      tbl[9]  = '{8'h00, 1'b1, 8'hFF, 8'hA5};
      tbl[10] = '{8'h06, 1'b1, 8'h55, 8'h00};
      tbl[11] = '{8'h07, 1'b1, 8'h55, 8'h00};
      tbl[12] = '{8'h20, 1'b1, 8'h77, 8'h00};
      tbl[13] = '{8'h03, 1'b1, 8'hEE, 8'h00};
`ifdef I2C_REG_BANK_IRQ_EN
      tbl[14] = '{8'h05, 1'b1, 8'h5A, 8'h5A};
`else
      tbl[14] = '{8'h05, 1'b1, 8'h5A, 8'h00};
`endif
      tbl[15] = '{8'h0C, 1'b0, 8'h00, 8'h15};

      repeat (3) @(negedge clk);
      check("rdata_in_reset", rdata, 8'h00);
      rst = 1'b0;
      check("tx_valid_reset", tx_valid, 1'b0);
      check("tx_data_reset", tx_data, 8'h00);
      check("rx_ready_reset", rx_ready, 1'b1);
      check("ctrl_reset", ctrl_o, 8'h00);
      check("gp_reset", gp_o, 64'h0);
      rd(8'h00, v); check("id_read", v, 8'hA5);
      rd(8'h01, v); check("ctrl_read_reset", v, 8'h00);
      rd(8'h02, v); check("status_read_reset", v, 8'h00);
      rd(8'h08, v); check("gp0_read_reset", v, 8'h00);

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].we) wr(tbl[i].a, tbl[i].wd);
         rd(tbl[i].a, v);
         check($sformatf("reg_vec%0d", i), v, tbl[i].exp);
      end
      check("ctrl_o", ctrl_o, 8'h3C);
      check("gp_o", gp_o, 64'h1817161514131211);

      // nine pushes into an 8-deep TX FIFO: the last one overflows
      for (int i = 1; i <= 9; i++) wr(8'h04, 8'(i));
      rd(8'h03, v); check("tx_level_full", v, 8'h80);
      rd(8'h02, v); check("status_tx_ovf", v, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check($sformatf("tx_valid_drain%0d", i), tx_valid, 1'b1);
         check($sformatf("tx_data_drain%0d", i), tx_data, 8'(i));
         tx_ready = 1'b1;
         @(negedge clk);
         tx_ready = 1'b0;
      end
      check("tx_valid_drained", tx_valid, 1'b0);
      check("tx_data_drained", tx_data, 8'h00);
      wr(8'h02, 8'h01);
      rd(8'h02, v); check("status_w1c_tx", v, 8'h00);

      // full TX with same-cycle pop accepts the push without overflow
      for (int i = 0; i < 8; i++) wr(8'h04, 8'h20 + 8'(i));
      @(negedge clk);
      addr = 8'h04; wdata = 8'h28; wen = 1'b1; tx_ready = 1'b1;
      @(negedge clk);
      wen = 1'b0; tx_ready = 1'b0;
      rd(8'h03, v); check("tx_full_pushpop_level", v, 8'h80);
      rd(8'h02, v); check("tx_full_pushpop_status", v, 8'h00);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check($sformatf("tx_data_pp%0d", i), tx_data, 8'h20 + 8'(i));
         tx_ready = 1'b1;
         @(negedge clk);
         tx_ready = 1'b0;
      end
      // empty TX with same-cycle pop keeps the pushed byte
      @(negedge clk);
      addr = 8'h04; wdata = 8'h33; wen = 1'b1; tx_ready = 1'b1;
      @(negedge clk);
      wen = 1'b0; tx_ready = 1'b0;
      check("tx_empty_pushpop_valid", tx_valid, 1'b1);
      check("tx_empty_pushpop_data", tx_data, 8'h33);
      rd(8'h03, v); check("tx_empty_pushpop_level", v, 8'h10);
      @(negedge clk); tx_ready = 1'b1;
      @(negedge clk); tx_ready = 1'b0;

      rx_push(8'hAA);
      rx_push(8'hBB);
      rd(8'h03, v); check("rx_level2", v, 8'h02);
      mbox_read(v); check("rx_read_aa", v, 8'hAA);
      mbox_read(v); check("rx_read_bb", v, 8'hBB);
      mbox_read(v); check("rx_read_empty", v, 8'h00);
      rd(8'h02, v); check("status_rx_unf", v, 8'h02);
      rd(8'h03, v); check("rx_level_empty", v, 8'h00);
      wr(8'h02, 8'h02);
      rd(8'h01, v); check("rdata_used_ctrl_noeffect", v, 8'h3C);

      // full RX with same-cycle pop and push keeps the level at 8
      for (int i = 0; i < 8; i++) rx_push(8'h40 + 8'(i));
      @(negedge clk);
      check("rx_ready_full", rx_ready, 1'b0);
      addr = 8'h04;
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'h48; rdata_used = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; rdata_used = 1'b0;
      rd(8'h03, v); check("rx_full_pushpop_level", v, 8'h08);
      for (int i = 1; i <= 8; i++) begin
         mbox_read(v);
         check($sformatf("rx_pp_read%0d", i), v, 8'h40 + 8'(i));
      end
      @(negedge clk);
      check("rx_ready_after_drain", rx_ready, 1'b1);

      @(negedge clk); status_set_i = 8'h04;
      @(negedge clk); status_set_i = 8'h00;
      rd(8'h02, v); check("status_sticky_set", v, 8'h04);
      @(negedge clk);
      addr = 8'h02; wdata = 8'h04; wen = 1'b1; status_set_i = 8'h04;
      @(negedge clk);
      wen = 1'b0; status_set_i = 8'h00;
      rd(8'h02, v); check("status_set_beats_w1c", v, 8'h04);
      wr(8'h02, 8'h04);
      rd(8'h02, v); check("status_w1c_clear", v, 8'h00);
      @(negedge clk); status_set_i = 8'h03;
      @(negedge clk); status_set_i = 8'h00;
      rd(8'h02, v); check("status_low_bits_ignored", v, 8'h00);

`ifdef I2C_REG_BANK_IRQ_EN
      wr(8'h05, 8'h01);
      for (int i = 0; i < 8; i++) wr(8'h04, 8'(i));
      @(negedge clk);
      check("irq_idle", irq, 1'b0);
      addr = 8'h04; wdata = 8'hFF; wen = 1'b1;
      @(negedge clk);
      wen = 1'b0;
      check("irq_before", irq, 1'b0);
      @(negedge clk);
      check("irq_set", irq, 1'b1);
      wr(8'h02, 8'h01);
      @(negedge clk);
      check("irq_cleared", irq, 1'b0);
      repeat (8) begin
         @(negedge clk); tx_ready = 1'b1;
         @(negedge clk); tx_ready = 1'b0;
      end
`endif

      // reset with a write strobe in flight discards FIFO contents and the strobe
      wr(8'h04, 8'h77);
      rx_push(8'h66);
      @(negedge clk);
      rst = 1'b1; addr = 8'h01; wdata = 8'h99; wen = 1'b1;
      @(negedge clk);
      rst = 1'b0; wen = 1'b0;
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_rx_ready", rx_ready, 1'b1);
      check("rst_ctrl", ctrl_o, 8'h00);
      rd(8'h03, v); check("rst_level", v, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
